// File: rtl/kf_frame_sequencer.sv
// kf_frame_sequencer
// ------------------
// Launching-side sequencer for the 2x2 fixed-point Kalman core (top_kf).
// Accepts one measurement frame per iteration on a valid/ready stream and
// presents the frame and the current state estimate to the core. It then
// pulses kf_start once and waits for kf_done. The posterior is captured,
// delivered on an output stream, and fed back as the next prior state.
// A frame whose done never arrives is abandoned after TIMEOUT_CYC wait
// cycles.
//
// Optional build macro: KF_SEQ_LAT_CHECK_EN
//   When defined, adds the sticky output lat_err. It flags a kf_done that
//   arrives at any wait count other than EXP_LAT-1.
//
// Ports
//   clk, rst_n                 clock (posedge), async active-low reset
//   init_load, init_x0/x1      load the initial state (honoured in IDLE only)
//   meas_valid/ready, meas_z*  measurement frame stream in
//   kf_start                   one-cycle launch pulse to top_kf
//   kf_x*0_prev, kf_z*0        registered operands to top_kf
//   kf_done, kf_X*0_post       completion and posterior from top_kf
//   out_valid/ready, out_x*    posterior result stream out
//   busy                       sequencer not idle
//   err_timeout                sticky frame-timeout flag
//   frame_cnt                  delivered frame count (wraps)
//   lat_err                    sticky latency mismatch (macro build only)

module kf_frame_sequencer #(
  parameter int N           = 20,
  parameter int FRAC        = 10,
  parameter int EXP_LAT     = 34,
  parameter int TIMEOUT_CYC = 48,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 init_load,
  input  logic [N-1:0]         init_x0,
  input  logic [N-1:0]         init_x1,
  input  logic                 meas_valid,
  output logic                 meas_ready,
  input  logic [N-1:0]         meas_z0,
  input  logic [N-1:0]         meas_z1,
  output logic                 kf_start,
  output logic [N-1:0]         kf_x00_prev,
  output logic [N-1:0]         kf_x10_prev,
  output logic [N-1:0]         kf_z00,
  output logic [N-1:0]         kf_z10,
  input  logic                 kf_done,
  input  logic [N-1:0]         kf_X00_post,
  input  logic [N-1:0]         kf_X10_post,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_x0,
  output logic [N-1:0]         out_x1,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [CNT_W-1:0]     frame_cnt
`ifdef KF_SEQ_LAT_CHECK_EN
  ,
  output logic                 lat_err
`endif
);

  // Wait counter must be able to hold TIMEOUT_CYC-1.
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  // Reject configurations where a nominal done would already be a timeout,
  // or where the Q format has no integer bits.
  generate
    if ((TIMEOUT_CYC <= EXP_LAT) || (FRAC >= N)) begin : g_bad_cfg
      $error("kf_frame_sequencer: need TIMEOUT_CYC > EXP_LAT and FRAC < N");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    x0_r;
  logic [N-1:0]    x1_r;
  logic            meas_ready_s;
  logic            accept_s;
  logic            done_s;
  logic            timeout_s;
  logic            deliver_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_nxt_s  = state_r;
    meas_ready_s = 1'b0;
    accept_s     = 1'b0;
    done_s       = 1'b0;
    timeout_s    = 1'b0;
    deliver_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // init_load wins over a pending frame: the frame waits one cycle
        // and then launches with the freshly loaded state.
        meas_ready_s = !init_load;
        if (meas_valid && !init_load) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_LAUNCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (kf_done) begin
          done_s      = 1'b1;
          state_nxt_s = ST_OUT;
        end else if (cnt_r == CW'(TIMEOUT_CYC - 1)) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          deliver_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign meas_ready = meas_ready_s;
  assign kf_start   = (state_r == ST_LAUNCH);
  assign busy       = (state_r != ST_IDLE);

  // Wait counter: zeroed on the launch edge, counts each WAIT cycle
  // without done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_LAUNCH) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == ST_WAIT) && !done_s && !timeout_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // State estimate: loaded by init_load in IDLE, replaced by each posterior.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_r <= {N{1'b0}};
      x1_r <= {N{1'b0}};
    end else if ((state_r == ST_IDLE) && init_load) begin
      x0_r <= init_x0;
      x1_r <= init_x1;
    end else if (done_s) begin
      x0_r <= kf_X00_post;
      x1_r <= kf_X10_post;
    end else begin
      x0_r <= x0_r;
      x1_r <= x1_r;
    end
  end

  // Core operands: captured at frame acceptance and held until the next
  // frame, so they are stable from LAUNCH through done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kf_x00_prev <= {N{1'b0}};
      kf_x10_prev <= {N{1'b0}};
      kf_z00      <= {N{1'b0}};
      kf_z10      <= {N{1'b0}};
    end else if (accept_s) begin
      kf_x00_prev <= x0_r;
      kf_x10_prev <= x1_r;
      kf_z00      <= meas_z0;
      kf_z10      <= meas_z1;
    end else begin
      kf_x00_prev <= kf_x00_prev;
      kf_x10_prev <= kf_x10_prev;
      kf_z00      <= kf_z00;
      kf_z10      <= kf_z10;
    end
  end

  // Output stream: posterior captured on done, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_x0    <= {N{1'b0}};
      out_x1    <= {N{1'b0}};
      frame_cnt <= {CNT_W{1'b0}};
    end else if (done_s) begin
      out_valid <= 1'b1;
      out_x0    <= kf_X00_post;
      out_x1    <= kf_X10_post;
      frame_cnt <= frame_cnt;
    end else if (deliver_s) begin
      out_valid <= 1'b0;
      out_x0    <= out_x0;
      out_x1    <= out_x1;
      frame_cnt <= frame_cnt + CNT_W'(1);
    end else begin
      out_valid <= out_valid;
      out_x0    <= out_x0;
      out_x1    <= out_x1;
      frame_cnt <= frame_cnt;
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout <= 1'b0;
    end else if (timeout_s) begin
      err_timeout <= 1'b1;
    end else begin
      err_timeout <= err_timeout;
    end
  end

`ifdef KF_SEQ_LAT_CHECK_EN
  // Sticky latency flag: done accepted at an unexpected wait count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_err <= 1'b0;
    end else if (done_s && (cnt_r != CW'(EXP_LAT - 1))) begin
      lat_err <= 1'b1;
    end else begin
      lat_err <= lat_err;
    end
  end
`endif

endmodule

// File: tb/tb_kf_frame_sequencer.sv
// Directed, table-driven bench for kf_frame_sequencer. It acts as a
// stand-in top_kf that raises kf_done at a chosen wait count. It also acts
// as the downstream consumer with configurable backpressure.

module tb_kf_frame_sequencer;

  localparam int N       = 20;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 48;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             init_load = 1'b0;
  logic [N-1:0]     init_x0 = '0;
  logic [N-1:0]     init_x1 = '0;
  logic             meas_valid = 1'b0;
  logic             meas_ready;
  logic [N-1:0]     meas_z0 = '0;
  logic [N-1:0]     meas_z1 = '0;
  logic             kf_start;
  logic [N-1:0]     kf_x00_prev, kf_x10_prev, kf_z00, kf_z10;
  logic             kf_done = 1'b0;
  logic [N-1:0]     kf_X00_post = '0;
  logic [N-1:0]     kf_X10_post = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_x0, out_x1;
  logic             busy;
  logic             err_timeout;
  logic [CNT_W-1:0] frame_cnt;
`ifdef KF_SEQ_LAT_CHECK_EN
  logic             lat_err;
`endif

  kf_frame_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .init_load(init_load), .init_x0(init_x0), .init_x1(init_x1),
    .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_z0(meas_z0), .meas_z1(meas_z1),
    .kf_start(kf_start),
    .kf_x00_prev(kf_x00_prev), .kf_x10_prev(kf_x10_prev),
    .kf_z00(kf_z00), .kf_z10(kf_z10),
    .kf_done(kf_done), .kf_X00_post(kf_X00_post), .kf_X10_post(kf_X10_post),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x0(out_x0), .out_x1(out_x1),
    .busy(busy), .err_timeout(err_timeout), .frame_cnt(frame_cnt)
`ifdef KF_SEQ_LAT_CHECK_EN
    , .lat_err(lat_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  always @(posedge clk) begin
    if (kf_start) starts <= starts + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int sx(input logic [N-1:0] v);
    return int'($signed(v));
  endfunction

  // dcnt: wait count at which done is raised (-1 = never, timeout).
  typedef struct {
    bit init;
    int ix0, ix1, z0, z1, dcnt, p0, p1, hold, xp0, xp1, fc;
    bit err, lat;
  } vec_t;

  vec_t tab[6];

  task automatic run_vec(input vec_t v, input string tag);
    int bad;
    meas_valid = 1'b1;
    meas_z0    = N'(v.z0);
    meas_z1    = N'(v.z1);
    init_load  = v.init;
    init_x0    = N'(v.ix0);
    init_x1    = N'(v.ix1);
    #1 chk({tag, " meas_ready"}, int'(meas_ready), v.init ? 0 : 1);
    if (v.init) begin
      @(negedge clk);
      init_load = 1'b0;
      #1 chk({tag, " meas_ready_after_init"}, int'(meas_ready), 1);
    end
    @(negedge clk);
    meas_valid = 1'b0;
    chk({tag, " kf_start"}, int'(kf_start), 1);
    chk({tag, " busy"}, int'(busy), 1);
    chk({tag, " x00_prev"}, sx(kf_x00_prev), v.xp0);
    chk({tag, " x10_prev"}, sx(kf_x10_prev), v.xp1);
    chk({tag, " z00"}, sx(kf_z00), v.z0);
    chk({tag, " z10"}, sx(kf_z10), v.z1);
    bad = 0;
    if (v.dcnt >= 0) begin
      repeat (v.dcnt + 1) begin
        @(negedge clk);
        if (kf_start || meas_ready || out_valid || !busy ||
            sx(kf_x00_prev) != v.xp0 || sx(kf_x10_prev) != v.xp1 ||
            sx(kf_z00) != v.z0 || sx(kf_z10) != v.z1) bad++;
      end
      kf_done     = 1'b1;
      kf_X00_post = N'(v.p0);
      kf_X10_post = N'(v.p1);
      @(negedge clk);
      kf_done     = 1'b0;
      kf_X00_post = 20'hAAAAA;
      kf_X10_post = 20'h55555;
      chk({tag, " hold_during_wait"}, bad, 0);
      chk({tag, " out_valid"}, int'(out_valid), 1);
      chk({tag, " out_x0"}, sx(out_x0), v.p0);
      chk({tag, " out_x1"}, sx(out_x1), v.p1);
      bad = 0;
      repeat (v.hold) begin
        @(negedge clk);
        if (!out_valid || meas_ready || kf_start ||
            sx(out_x0) != v.p0 || sx(out_x1) != v.p1) bad++;
      end
      chk({tag, " backpressure_hold"}, bad, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, " out_valid_after_accept"}, int'(out_valid), 0);
      chk({tag, " busy_after_accept"}, int'(busy), 0);
    end else begin
      repeat (TIMEOUT) begin
        @(negedge clk);
        if (kf_start || out_valid || !busy || err_timeout) bad++;
      end
      chk({tag, " wait_until_last_count"}, bad, 0);
      @(negedge clk);
      chk({tag, " busy_after_timeout"}, int'(busy), 0);
      chk({tag, " out_valid_after_timeout"}, int'(out_valid), 0);
    end
    chk({tag, " frame_cnt"}, int'(frame_cnt), v.fc);
    chk({tag, " err_timeout"}, int'(err_timeout), int'(v.err));
`ifdef KF_SEQ_LAT_CHECK_EN
    chk({tag, " lat_err"}, int'(lat_err), int'(v.lat));
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " kf_start"}, int'(kf_start), 0);
    chk({tag, " kf_x_prev"}, int'(kf_x00_prev | kf_x10_prev), 0);
    chk({tag, " kf_z"}, int'(kf_z00 | kf_z10), 0);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " out_x"}, int'(out_x0 | out_x1), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " err_timeout"}, int'(err_timeout), 0);
    chk({tag, " frame_cnt"}, int'(frame_cnt), 0);
`ifdef KF_SEQ_LAT_CHECK_EN
    chk({tag, " lat_err"}, int'(lat_err), 0);
`endif
  endtask

  initial begin
    //            init ix0   ix1    z0   z1   dcnt p0      p1       hold xp0   xp1   fc err lat
    tab[0] = '{1'b1, 512,  -256,  100, -50, 33,  300,    -150,    0,   512,  -256, 1, 1'b0, 1'b0};
    tab[1] = '{1'b0, 0,    0,     120, -40, 33,  310,    -160,    10,  300,  -150, 2, 1'b0, 1'b0};
    tab[2] = '{1'b0, 0,    0,     7,   8,   -1,  0,      0,       0,   310,  -160, 2, 1'b1, 1'b0};
    tab[3] = '{1'b0, 0,    0,     -1,  1,   33,  524287, -524288, 2,   310,  -160, 3, 1'b1, 1'b0};
    tab[4] = '{1'b1, 1024, -1024, 50,  60,  30,  11,     22,      0,   1024, -1024, 4, 1'b1, 1'b1};
    tab[5] = '{1'b0, 0,    0,     9,   -9,  33,  77,     -77,     1,   0,    0,    1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset meas_ready", int'(meas_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_vec(tab[i], $sformatf("vec%0d", i));
    end

    // done while idle must be ignored
    kf_done = 1'b1;
    kf_X00_post = 20'h12345;
    @(negedge clk);
    kf_done = 1'b0;
    chk("idle_done busy", int'(busy), 0);
    chk("idle_done out_valid", int'(out_valid), 0);
    chk("idle_done frame_cnt", int'(frame_cnt), 4);

    // reset in the middle of WAIT, then a late done
    meas_valid = 1'b1;
    meas_z0 = N'(3);
    meas_z1 = N'(4);
    @(negedge clk);
    meas_valid = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    kf_done = 1'b1;
    kf_X00_post = N'(999);
    kf_X10_post = N'(888);
    @(negedge clk);
    kf_done = 1'b0;
    chk("late_done out_valid", int'(out_valid), 0);
    chk("late_done busy", int'(busy), 0);
    chk("late_done frame_cnt", int'(frame_cnt), 0);
    chk("late_done out_x0", int'(out_x0), 0);

    // state was cleared by reset, so the next frame launches from x=0
    run_vec(tab[5], "vec5");

    chk("kf_start_pulses", starts, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
